spad_fifo_ctrl: RTL
===================

Name: spad_fifo_ctrl

Overview:
- FIFO controller for one single-port scratchpad (SPad_SP: one port, read or write per cycle, read data one cycle after the read enable, unregistered).
- Accepts a valid/ready input stream, writes words to the spad at a wrapping write pointer, and reads them back in order into a one-entry output register that drives a valid/ready output stream.
- Used to buffer PE operand streams (iact/weight/psum) in front of the spad.

Parameters:
- DATA_WIDTH, 8, word width; must match the attached spad.
- ADDR_WIDTH, 4, spad address width; DEPTH = 2**ADDR_WIDTH words.

Ports:
- clk_i  in  1  clock, all state on rising edge.
- rst_ni  in  1  synchronous, active-low reset.
- data_i  in  DATA_WIDTH  input word.
- valid_i  in  1  input word valid.
- ready_o  out  1  input accepted when valid_i&ready_o.
- data_o  out  DATA_WIDTH  output word (output register).
- valid_o  out  1  output register holds a word.
- ready_i  in  1  consumer pops when valid_o&ready_i.
- spad_re_o  out  1  spad read enable.
- spad_we_o  out  1  spad write enable.
- spad_addr_o  out  ADDR_WIDTH  spad address.
- spad_wdata_o  out  DATA_WIDTH  spad write data (= data_i).
- spad_rdata_i  in  DATA_WIDTH  spad read data, valid the cycle after spad_re_o.
- count_o  out  ADDR_WIDTH+1  words held: mem_cnt + rd_pend + out_valid.
- full_o  out  1  mem_cnt == DEPTH.
- empty_o  out  1  count_o == 0.

Behaviour:
- State: wr_ptr and rd_ptr (ADDR_WIDTH bits, wrap DEPTH-1 -> 0), mem_cnt (0..DEPTH), rd_pend, out_valid, out_data, prio (0 = write priority, 1 = read priority).
- Reset (rst_ni=0 at an edge): all state 0, prio=0. Outputs: valid_o=0, count_o=0, empty_o=1, full_o=0.
- While rst_ni=0: ready_o=0, spad_re_o=0, spad_we_o=0. Spad contents are not cleared.
- Reset mid-operation discards every word, including one in flight; the following spad_rdata_i is ignored.
- pop = valid_o & ready_i.
- rd_elig = (mem_cnt>0) & !rd_pend & (!out_valid | pop).
- wr_req = valid_i & (mem_cnt<DEPTH).
- Arbitration, single port:
  - Only one requester: it is granted.
  - Both: prio=0 grants write, prio=1 grants read. prio toggles after every contested cycle and holds otherwise.
- ready_o = (mem_cnt<DEPTH) & !(rd_elig & prio). This is combinational on ready_i via pop; this path is accepted.
- Write grant (valid_i&ready_o): spad_we_o=1, spad_addr_o=wr_ptr, wr_ptr++, mem_cnt++.
- Read grant: spad_re_o=1, spad_addr_o=rd_ptr, rd_ptr++, mem_cnt--, rd_pend<=1.
- spad_re_o and spad_we_o are never high together. Idle: spad_addr_o=rd_ptr, spad_wdata_o=data_i.
- rd_pend=1 at an edge: out_data<=spad_rdata_i, out_valid<=1, rd_pend<=0.
- Otherwise pop clears out_valid. out_data holds when not loaded.
- Latency: a word written in cycle t into an empty FIFO is read in t+1 and shows valid_o at t+3.
- Throughput limits:
  - Sustained output ≤ 1 word per 2 cycles (read issue requires !rd_pend).
  - Combined spad traffic ≤ 1 access per cycle.
- Full (mem_cnt=DEPTH): ready_o=0. The output register may still hold a word, so count_o max = DEPTH+1.
- Empty: no read issued; valid_o falls after the final pop.
- Simultaneous write and read in one cycle is impossible by construction, so mem_cnt changes by at most ±1 per cycle.
- Pointer wrap needs no special case.

Test Plan:
- Reset then idle, valid_i=0: valid_o=0, count_o=0, empty_o=1, spad_re_o=spad_we_o=0 for 10 cycles.
- Write 0x11 at cycle 0, ready_i=1: spad_we_o at addr 0 in cycle 0; spad_re_o at addr 0 in cycle 1; valid_o=1 with data_o=0x11 in cycle 3; empty_o=1 after the pop.
- ADDR_WIDTH=4, ready_i=0, write 0x00..0x10 back-to-back:
  - First word moves to the output register.
  - full_o=1 after 17 accepts (count_o=17).
  - ready_o=0 on the 18th offer; valid_o=1 with data_o=0x00.
- Continuous valid_i and ready_i from empty:
  - Spad strobes alternate per prio; never both high.
  - Output sequence is in order with no loss or duplication over 200 random words.
  - rd_ptr/wr_ptr wrap past 15 correctly.
- Read issued at cycle t, rst_ni=0 at t+1, spad_rdata_i=0xAA:
  - After reset valid_o=0 and count_o=0.
  - 0xAA never appears on data_o.
- Output held with ready_i=0 for 5 cycles:
  - data_o and valid_o stable.
  - No further read until the pop; spad_re_o is asserted in the pop cycle.

Source files
------------

// File: rtl/spad_fifo_ctrl.sv
// FIFO controller for one single-port scratchpad (one access per cycle,
// read data returned the cycle after the read enable).
// The input stream is written to the spad at a wrapping write pointer. Words are read back in
// order into a one-entry output register that drives the output stream.
//
// Ports:
//   clk_i, rst_ni             clock, synchronous active-low reset
//   data_i/valid_i/ready_o    input stream
//   data_o/valid_o/ready_i    output stream (data_o is the output register)
//   spad_re_o, spad_we_o      spad strobes, never high together
//   spad_addr_o               spad address (write pointer on write, else read pointer)
//   spad_wdata_o              spad write data, equal to data_i
//   spad_rdata_i              spad read data, valid the cycle after spad_re_o
//   count_o                   words held: in spad + in flight + in output register
//   full_o, empty_o           spad full, nothing held at all
module spad_fifo_ctrl #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic                  spad_re_o,
  output logic                  spad_we_o,
  output logic [ADDR_WIDTH-1:0] spad_addr_o,
  output logic [DATA_WIDTH-1:0] spad_wdata_o,
  input  logic [DATA_WIDTH-1:0] spad_rdata_i,
  output logic [ADDR_WIDTH:0]   count_o,
  output logic                  full_o,
  output logic                  empty_o
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
  localparam int unsigned CW    = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] DepthC = CW'(DEPTH);

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         mem_cnt_q, mem_cnt_d;
  logic                  rd_pend_q, rd_pend_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                  prio_q, prio_d;

  logic pop, not_full, rd_elig, wr_gnt, rd_gnt, contested;

  always_comb begin
    pop       = out_valid_q & ready_i;
    not_full  = mem_cnt_q < DepthC;
    // A read may issue only if its data can land in a free (or freeing) output register.
    rd_elig   = (mem_cnt_q != '0) & ~rd_pend_q & (~out_valid_q | pop);
    contested = valid_i & not_full & rd_elig;
    // Under read priority the write is held off whenever a read is eligible.
    ready_o   = rst_ni & not_full & ~(rd_elig & prio_q);
    wr_gnt    = valid_i & ready_o;
    rd_gnt    = rst_ni & rd_elig & ~wr_gnt;
  end

  always_comb begin
    spad_we_o    = wr_gnt;
    spad_re_o    = rd_gnt;
    spad_addr_o  = wr_gnt ? wr_ptr_q : rd_ptr_q;
    spad_wdata_o = data_i;
    data_o       = out_data_q;
    valid_o      = out_valid_q;
    count_o      = mem_cnt_q + CW'(rd_pend_q) + CW'(out_valid_q);
    full_o       = (mem_cnt_q == DepthC);
    empty_o      = (count_o == '0);
  end

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    mem_cnt_d   = mem_cnt_q;
    rd_pend_d   = 1'b0;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    prio_d      = prio_q;

    if (wr_gnt) begin
      wr_ptr_d  = wr_ptr_q + ADDR_WIDTH'(1);
      mem_cnt_d = mem_cnt_q + CW'(1);
    end else if (rd_gnt) begin
      rd_ptr_d  = rd_ptr_q + ADDR_WIDTH'(1);
      mem_cnt_d = mem_cnt_q - CW'(1);
      rd_pend_d = 1'b1;
    end

    if (rd_pend_q) begin
      out_data_d  = spad_rdata_i;
      out_valid_d = 1'b1;
    end else if (pop) begin
      out_valid_d = 1'b0;
    end

    if (contested) begin
      prio_d = ~prio_q;
    end
  end

  // Reset drops any in-flight read, so the following spad_rdata_i is never captured.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      mem_cnt_q   <= '0;
      rd_pend_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      prio_q      <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      mem_cnt_q   <= mem_cnt_d;
      rd_pend_q   <= rd_pend_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      prio_q      <= prio_d;
    end
  end

endmodule
